// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: on a conflict the side that did not win last time wins.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_grant,
    output logic grant_a,
    output logic grant_b
);

    logic b_was_last;

    assign b_was_last = (grant_t'(last_grant) == GRANT_B);

    assign grant_a = a_valid && (!b_valid || b_was_last);
    assign grant_b = b_valid && (!a_valid || !b_was_last);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-clears all registers after reset, then
// round-robin arbitrates writes from A and B. Optional counters under REGARB_STATS_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS           = REG_COUNT,
    parameter int ADDR_W             = REG_ADDR_W,
    parameter int DATA_W             = REG_DATA_W,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              init_busy
`ifdef REGARB_STATS_EN
    ,
    output logic [15:0]       conflict_count,
    output logic [7:0]        zero_drop_count
`endif
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    state_t            state, state_next;
    grant_t            last_grant, last_next;
    logic [ADDR_W:0]   clear_idx, idx_next;
    logic              wr_next;
    logic [ADDR_W-1:0] reg_next;
    logic [DATA_W-1:0] data_next;

    logic              grant_a, grant_b;
    logic              hs_a, hs_b, win_valid, zero_drop;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;

    rr_arbiter2 u_arb (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (last_grant),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    // Ready is suppressed during reset so no handshake completes on a cycle whose write is dropped.
    assign a_ready   = (state == RUN) && !reset && grant_a;
    assign b_ready   = (state == RUN) && !reset && grant_b;
    assign init_busy = (state == CLEAR);

    assign hs_a      = a_valid && a_ready;
    assign hs_b      = b_valid && b_ready;
    assign win_valid = hs_a || hs_b;
    assign win_reg   = hs_a ? a_reg  : b_reg;
    assign win_data  = hs_a ? a_data : b_data;
    assign zero_drop = win_valid && (ZERO_REG_HARDWIRED != 0) && (win_reg == '0);

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = clear_idx;
        last_next  = last_grant;
        wr_next    = 1'b0;
        reg_next   = rf_writeReg;
        data_next  = rf_writeData;
        case (state)
            CLEAR: begin
                wr_next   = 1'b1;
                reg_next  = clear_idx[ADDR_W-1:0];
                data_next = '0;
                idx_next  = clear_idx + IDX_ONE;
                if (clear_idx == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (win_valid) begin
                    last_next = hs_a ? GRANT_A : GRANT_B;
                    reg_next  = win_reg;
                    data_next = win_data;
                    wr_next   = !zero_drop;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clear_idx    <= '0;
            last_grant   <= GRANT_B;
            rf_write     <= 1'b0;
            rf_writeReg  <= '0;
            rf_writeData <= '0;
        end else begin
            state        <= state_next;
            clear_idx    <= idx_next;
            last_grant   <= last_next;
            rf_write     <= wr_next;
            rf_writeReg  <= reg_next;
            rf_writeData <= data_next;
        end
    end

`ifdef REGARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count  <= '0;
            zero_drop_count <= '0;
        end else begin
            if ((state == RUN) && a_valid && b_valid && (conflict_count != 16'hFFFF)) begin
                conflict_count <= conflict_count + 16'd1;
            end
            if (zero_drop && (zero_drop_count != 8'hFF)) begin
                zero_drop_count <= zero_drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model; also checks counters when REGARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        rf_write;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic        init_busy;
`ifdef REGARB_STATS_EN
    logic [15:0] conflict_count;
    logic [7:0]  zero_drop_count;
`endif

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .rf_write     (rf_write),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .init_busy    (init_busy)
`ifdef REGARB_STATS_EN
        ,
        .conflict_count  (conflict_count),
        .zero_drop_count (zero_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int          clear_left;
    int          next_clear;
    int          last_win;     // 0 = A, 1 = B
    int          cyc_win;      // winner of the most recent cycle, -1 if none
    logic        exp_known;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [31:0] mem [32];     // register file contents as seen through the write port
    int          m_conf;
    int          m_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic cycle();
        logic exp_wr;
        int   win;
        @(negedge clk);
        win = -1;
        if (!reset && clear_left == 0) begin
            if (a_valid && b_valid) win = (last_win == 1) ? 0 : 1;
            else if (a_valid)       win = 0;
            else if (b_valid)       win = 1;
        end
        check("a_ready", 32'(a_ready), 32'(win == 0));
        check("b_ready", 32'(b_ready), 32'(win == 1));
        cyc_win = win;

        exp_wr = 1'b0;
        if (reset) begin
            clear_left = 32;
            next_clear = 0;
            last_win   = 1;
            exp_known  = 1'b1;
            exp_reg    = '0;
            exp_data   = '0;
            m_conf     = 0;
            m_zero     = 0;
        end else if (clear_left > 0) begin
            exp_wr     = 1'b1;
            exp_known  = 1'b1;
            exp_reg    = 5'(next_clear);
            exp_data   = '0;
            next_clear++;
            clear_left--;
        end else begin
            if (a_valid && b_valid && m_conf < 65535) m_conf++;
            if (win >= 0) begin
                last_win = win;
                exp_reg  = (win == 0) ? a_reg  : b_reg;
                exp_data = (win == 0) ? a_data : b_data;
                if (exp_reg == 5'd0) begin
                    exp_known = 1'b0;
                    if (m_zero < 255) m_zero++;
                end else begin
                    exp_wr    = 1'b1;
                    exp_known = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        check("rf_write", 32'(rf_write), 32'(exp_wr));
        if (exp_known) begin
            check("rf_writeReg", 32'(rf_writeReg), 32'(exp_reg));
            check("rf_writeData", rf_writeData, exp_data);
        end
        check("init_busy", 32'(init_busy), 32'(clear_left > 0));
`ifdef REGARB_STATS_EN
        check("conflict_count", 32'(conflict_count), 32'(m_conf));
        check("zero_drop_count", 32'(zero_drop_count), 32'(m_zero));
`endif
        if (rf_write === 1'b1) mem[rf_writeReg] = rf_writeData;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEADBEEF;
        reset   = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        cyc_win = -1;
        clear_left = 32; next_clear = 0; last_win = 1;
        exp_known = 1'b0; exp_reg = '0; exp_data = '0;
        m_conf = 0; m_zero = 0;

        // Reset for two cycles, then the 32-write clear with A requesting throughout
        cycle();
        cycle();
        reset   = 1'b0;
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h55555555;
        for (int i = 0; i < 32; i++) cycle();
        a_valid = 1'b0;
        for (int i = 0; i < 32; i++) check("mem_cleared", mem[i], 32'h0);

        // A alone, then an idle cycle
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'hDDDDDDDD;
        cycle();
        a_valid = 1'b0;
        cycle();
        check("mem_r7", mem[7], 32'hDDDDDDDD);

        // B targets hardwired register 0
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h11111111;
        cycle();
        b_valid = 1'b0;
        cycle();
        check("mem_r0", mem[0], 32'h0);

        // Four-cycle conflict: expected A,B,A,B
        a_valid = 1'b1; a_reg = 5'd13; a_data = 32'hAAAAAAAA;
        b_valid = 1'b1; b_reg = 5'd11; b_data = 32'h15828762;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("conflict_winner", 32'(cyc_win), 32'(i % 2));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();
`ifdef REGARB_STATS_EN
        check("conflict_count_4", 32'(conflict_count), 32'd4);
        check("zero_drop_count_1", 32'(zero_drop_count), 32'd1);
`endif

        // Randomized traffic honouring the hold-while-not-ready rule
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || cyc_win == 0) begin
                a_valid = 1'($urandom_range(0, 1));
                a_reg   = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || cyc_win == 1) begin
                b_valid = 1'($urandom_range(0, 1));
                b_reg   = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();

        // Reset while a granted write is in flight
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99999999;
        cycle();
        reset = 1'b1;
        cycle();
        check("inflight_dropped", 32'(rf_write), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) cycle();
        a_valid = 1'b0;
        cycle();

        // Reset at clear index 20, then a full restart
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) cycle();
        check("restart_last_reg", 32'(rf_writeReg), 32'd31);
        cycle();
        check("restart_busy_low", 32'(init_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
